userio_osd_cmd: RTL and testbench
=================================

# userio_osd_cmd

OSD command decoder sitting directly downstream of the OSD SPI slave. It consumes the slave's synchronized byte strobe (`rx`), first-byte flag (`cmd`), received byte (`out`) and select-valid flag (`vld`). From these it produces OSD text-buffer write cycles, OSD enable/highlight state and a 16-bit config word. It also returns a status byte to the slave's parallel `in` input for the next SPI transfer.

## Interface
- No parameters.
- `clk`  in  1  pixel clock; all logic on posedge.
- `_reset`  in  1  asynchronous, active-low reset.
- `clk7_en`  in  1  clock enable; all state and outputs update only on `clk` edges with `clk7_en=1`.
- `rx`  in  1  byte-received strobe from SPI slave; high for exactly one `clk7_en`-qualified cycle per byte.
- `cmd`  in  1  high when the byte flagged by `rx` is the first byte after chip select.
- `din`  in  8  received byte (SPI slave `out`); stable while `rx=1`.
- `vld`  in  1  synchronized chip-select-active flag.
- `tx`  out  8  status byte to SPI slave `in`.
- `wr`  out  1  buffer write strobe.
- `wr_addr`  out  11  buffer address {line[2:0], col[7:0]}.
- `wr_data`  out  8  buffer write data.
- `osd_enable`  out  1  OSD display enable.
- `hl_line`  out  4  highlighted line; 4'hF = none.
- `cfg`  out  16  config word.
- `cfg_stb`  out  1  config-updated strobe.

## Operation
- Accepted byte: `clk7_en=1 && rx=1 && vld=1`. Bytes with `vld=0` are ignored.
- States: IDLE, WRLINE, CFGHI, CFGLO, IGNORE.
- Accepted byte with `cmd=1` is decoded in any state and aborts any command in progress:
  - 0x20–0x2F: line ← din[2:0]; col ← 0; go to WRLINE. din[3] is ignored.
  - 0x40–0x4F: osd_enable ← din[0]; go to IGNORE.
  - 0x50–0x5F: hl_line ← din[3:0]; go to IGNORE.
  - 0x80: go to CFGHI.
  - Any other value: go to IGNORE.
- Data bytes (`cmd=0`):
  - WRLINE: wr ← 1; wr_addr ← {line, col}; wr_data ← din; col ← col+1.
    - col wraps 255 → 0 within the same line; no carry into line.
  - CFGHI: cfg[15:8] ← din; go to CFGLO.
  - CFGLO: cfg[7:0] ← din; cfg_stb ← 1; go to IGNORE.
  - IDLE, IGNORE: byte is dropped.
- `vld=0` on any `clk7_en` cycle: state → IDLE.
  - A partial config (only CFGHI written) keeps its new high byte; cfg_stb is not raised.
- tx ← {4'hA, 2'b00, hl_line != 4'hF, osd_enable}, registered.

## Timing
- Reset values: state IDLE, tx 8'hA0, wr 0, wr_addr 0, wr_data 0, osd_enable 0, hl_line 4'hF, cfg 16'h0000, cfg_stb 0, internal line/col 0.
- Reset is asynchronous and independent of `clk7_en`.
  - Reset mid-command returns to IDLE. No partial write or strobe is emitted after release.
- Latency: an accepted byte at enabled edge N is visible on all outputs after edge N.
- `wr` and `cfg_stb` are high for exactly one enabled cycle, i.e. until enabled edge N+1. They are cleared on every enabled edge without a new event.
- Each data byte in WRLINE produces one `wr`; `wr_addr`/`wr_data` hold their value until the next write.
- tx updates one enabled edge after osd_enable/hl_line change. The SPI slave samples it at the next transfer's byte boundary.
- `cmd=1` and `vld=0` on the same enabled edge: `vld=0` wins; state goes to IDLE and the byte is dropped.

## Test plan
- Reset, then idle: tx=8'hA0, hl_line=4'hF, all strobes 0. Assert `_reset` low mid-WRLINE → outputs return to reset values immediately.
- CS; bytes 0x23, 0x11, 0x22, 0x33 → three `wr` pulses at wr_addr 11'h300, 11'h301, 11'h302 with wr_data 0x11, 0x22, 0x33.
- Command 0x27 followed by 257 data bytes → addresses 11'h700..11'h7FF then 11'h700 (wrap); line is never corrupted.
- 0x80, 0x12, 0x34 → cfg=16'h1234 and one cfg_stb pulse. Send 0x80, 0x56, then drop CS → cfg=16'h5634, no cfg_stb.
- 0x41 then 0x53 → osd_enable=1, hl_line=3, tx=8'hA3. 0x40 then 0x5F → tx=8'hA0.
- 0x24, 0xAA, then CS dropped and reasserted with data byte 0xBB flagged `cmd=0` (and a `vld=0` byte) → no write for 0xBB; exactly one write, of 0xAA at 11'h400.

Source files
------------

// File: rtl/userio_osd_cmd.sv
// OSD command decoder. Turns the byte stream from the OSD SPI slave into
// text-buffer writes, OSD enable/highlight state and a 16-bit config word,
// and returns a status byte for the slave to shift out on the next transfer.
module userio_osd_cmd (
  input  logic        clk,
  input  logic        _reset,
  input  logic        clk7_en,
  input  logic        rx,
  input  logic        cmd,
  input  logic [7:0]  din,
  input  logic        vld,
  output logic [7:0]  tx,
  output logic        wr,
  output logic [10:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        osd_enable,
  output logic [3:0]  hl_line,
  output logic [15:0] cfg,
  output logic        cfg_stb
);

  typedef enum logic [2:0] {
    StIdle,
    StWrLine,
    StCfgHi,
    StCfgLo,
    StIgnore
  } state_e;

  state_e      state_q;
  logic [2:0]  line_q;
  logic [7:0]  col_q;

  // Command FSM with all outputs registered; everything advances on enabled edges only.
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      state_q    <= StIdle;
      line_q     <= 3'd0;
      col_q      <= 8'd0;
      tx         <= 8'hA0;
      wr         <= 1'b0;
      wr_addr    <= 11'd0;
      wr_data    <= 8'd0;
      osd_enable <= 1'b0;
      hl_line    <= 4'hF;
      cfg        <= 16'h0000;
      cfg_stb    <= 1'b0;
    end else if (clk7_en) begin
      // Strobes last exactly one enabled cycle.
      wr      <= 1'b0;
      cfg_stb <= 1'b0;
      // Status reflects the state as it was before this edge.
      tx      <= {4'hA, 2'b00, hl_line != 4'hF, osd_enable};
      if (!vld) begin
        // Chip select gone: abandon any command, even if a byte is flagged.
        state_q <= StIdle;
      end else if (rx) begin
        if (cmd) begin
          case (din[7:4])
            4'h2: begin
              line_q  <= din[2:0];
              col_q   <= 8'd0;
              state_q <= StWrLine;
            end
            4'h4: begin
              osd_enable <= din[0];
              state_q    <= StIgnore;
            end
            4'h5: begin
              hl_line <= din[3:0];
              state_q <= StIgnore;
            end
            4'h8: state_q <= (din[3:0] == 4'h0) ? StCfgHi : StIgnore;
            default: state_q <= StIgnore;
          endcase
        end else begin
          unique case (state_q)
            StWrLine: begin
              wr      <= 1'b1;
              wr_addr <= {line_q, col_q};
              wr_data <= din;
              // Column wraps inside the line; the line never advances.
              col_q   <= col_q + 8'd1;
            end
            StCfgHi: begin
              cfg[15:8] <= din;
              state_q   <= StCfgLo;
            end
            StCfgLo: begin
              cfg[7:0] <= din;
              cfg_stb  <= 1'b1;
              state_q  <= StIgnore;
            end
            StIdle, StIgnore: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_userio_osd_cmd.sv
// Bench for userio_osd_cmd: a reference model predicts writes and config strobes
// into queues; a monitor pops and compares them whenever the DUT pulses a strobe.
module tb_userio_osd_cmd;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clk7_en, rx, cmd, vld;
  logic [7:0]  din;
  logic [7:0]  tx;
  logic        wr;
  logic [10:0] wr_addr;
  logic [7:0]  wr_data;
  logic        osd_enable;
  logic [3:0]  hl_line;
  logic [15:0] cfg;
  logic        cfg_stb;

  userio_osd_cmd dut (
    .clk        (clk),
    ._reset     (rst_n),
    .clk7_en    (clk7_en),
    .rx         (rx),
    .cmd        (cmd),
    .din        (din),
    .vld        (vld),
    .tx         (tx),
    .wr         (wr),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .osd_enable (osd_enable),
    .hl_line    (hl_line),
    .cfg        (cfg),
    .cfg_stb    (cfg_stb)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int n_wr   = 0;
  int n_stb  = 0;

  // Reference model: what the decoder is doing and what it has produced.
  // mode: 0 idle/ignoring, 1 writing a line, 2 expecting cfg high, 3 expecting cfg low
  int          mode;
  int          m_line, m_col;
  bit          m_osd;
  int          m_hl;
  logic [15:0] m_cfg;
  logic [7:0]  m_tx;
  logic [18:0] wq[$];
  logic [15:0] cq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mode = 0; m_line = 0; m_col = 0; m_osd = 0; m_hl = 15;
    m_cfg = 16'h0000; m_tx = 8'hA0;
  endtask

  task automatic model_byte(input bit c, input logic [7:0] d);
    if (c) begin
      mode = 0;
      if (d >= 8'h20 && d <= 8'h2F) begin
        m_line = d % 8; m_col = 0; mode = 1;
      end else if (d >= 8'h40 && d <= 8'h4F) m_osd = d[0];
      else if (d >= 8'h50 && d <= 8'h5F) m_hl = d % 16;
      else if (d == 8'h80) mode = 2;
    end else if (mode == 1) begin
      wq.push_back({3'(m_line), 8'(m_col), d});
      m_col = (m_col + 1) % 256;
    end else if (mode == 2) begin
      m_cfg = {d, m_cfg[7:0]}; mode = 3;
    end else if (mode == 3) begin
      m_cfg = {m_cfg[15:8], d}; cq.push_back(m_cfg); mode = 0;
    end
  endtask

  // One clock cycle of stimulus; the model advances only on enabled edges.
  task automatic cyc(input bit en, input bit r, input bit c, input logic [7:0] d, input bit v);
    @(negedge clk);
    clk7_en = en; rx = r; cmd = c; din = d; vld = v;
    if (en) begin
      m_tx = 8'hA0 + ((m_hl != 15) ? 8'd2 : 8'd0) + (m_osd ? 8'd1 : 8'd0);
      if (!v) mode = 0;
      else if (r) model_byte(c, d);
    end
  endtask

  // Disabled cycles carry random junk on rx/din, which must be ignored.
  task automatic gap(input int n);
    repeat (n) cyc(1'b0, 1'($urandom), 1'($urandom), 8'($urandom), 1'b1);
  endtask

  task automatic send(input bit c, input logic [7:0] d);
    cyc(1'b1, 1'b1, c, d, 1'b1);
    gap($urandom_range(0, 2));
  endtask

  task automatic idle_en();
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic drop_cs();
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  // Monitor: after each enabled edge, match strobes against the queues and status against the model.
  initial begin
    logic [18:0] ew;
    logic [15:0] ec;
    bit en_s, rst_s;
    forever begin
      @(posedge clk);
      en_s  = clk7_en;
      rst_s = rst_n;
      #1;
      if (en_s && rst_s) begin
        if (wr) begin
          n_wr++;
          if (wq.size() == 0) chk("unexpected_wr", {21'd0, wr_addr}, 32'hFFFFFFFF);
          else begin
            ew = wq.pop_front();
            chk("wr_addr_data", {13'd0, wr_addr, wr_data}, {13'd0, ew});
          end
        end
        if (cfg_stb) begin
          n_stb++;
          if (cq.size() == 0) chk("unexpected_cfg_stb", {16'd0, cfg}, 32'hFFFFFFFF);
          else begin
            ec = cq.pop_front();
            chk("cfg_at_stb", {16'd0, cfg}, {16'd0, ec});
          end
        end
        chk("status", {19'd0, tx, osd_enable, hl_line},
            {19'd0, m_tx, m_osd, 4'(m_hl)});
        chk("cfg", {16'd0, cfg}, {16'd0, m_cfg});
      end
    end
  end

  initial begin
    int w0, s0;
    logic [7:0] op;
    rst_n = 1'b0; clk7_en = 1'b0; rx = 1'b0; cmd = 1'b0; din = 8'h00; vld = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_tx", {24'd0, tx}, 32'hA0);
    chk("rst_hl", {28'd0, hl_line}, 32'hF);
    chk("rst_strobes", {30'd0, wr, cfg_stb}, 32'd0);
    rst_n = 1'b1;
    repeat (2) idle_en();

    // Basic line write.
    w0 = n_wr;
    send(1, 8'h23); send(0, 8'h11); send(0, 8'h22); send(0, 8'h33);
    idle_en();
    chk("basic_wr_count", n_wr - w0, 3);
    chk("basic_last_addr", {21'd0, wr_addr}, 32'h302);

    // Column wrap: 257 bytes on line 7.
    send(1, 8'h27);
    for (int i = 0; i < 257; i++) send(0, 8'(i * 7 + 1));
    idle_en();
    chk("wrap_addr", {21'd0, wr_addr}, 32'h700);

    // Full config then a partial one cut short by chip select.
    s0 = n_stb;
    send(1, 8'h80); send(0, 8'h12); send(0, 8'h34); idle_en();
    chk("cfg_full", {16'd0, cfg}, 32'h1234);
    chk("cfg_stb_count", n_stb - s0, 1);
    s0 = n_stb;
    send(1, 8'h80); send(0, 8'h56); drop_cs(); idle_en(); send(0, 8'h78); idle_en();
    chk("cfg_partial", {16'd0, cfg}, 32'h5634);
    chk("cfg_partial_no_stb", n_stb - s0, 0);

    // Enable/highlight and the lagging status byte.
    send(1, 8'h41); send(1, 8'h53); idle_en(); idle_en();
    chk("tx_on", {24'd0, tx}, 32'hA3);
    send(1, 8'h40); send(1, 8'h5F); idle_en(); idle_en();
    chk("tx_off", {24'd0, tx}, 32'hA0);

    // Chip select drop aborts the line; later data bytes go nowhere.
    w0 = n_wr;
    send(1, 8'h24); send(0, 8'hAA); drop_cs();
    cyc(1'b1, 1'b1, 1'b0, 8'hCC, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 8'h80, 1'b0);
    send(0, 8'hBB); idle_en();
    chk("abort_wr_count", n_wr - w0, 1);
    chk("abort_wr", {13'd0, wr_addr, wr_data}, {13'd0, 11'h400, 8'hAA});

    // Reset in the middle of a line write.
    send(1, 8'h25); send(0, 8'h01);
    @(negedge clk);
    clk7_en = 1'b0; rst_n = 1'b0;
    model_reset();
    #1;
    chk("midrst_tx", {24'd0, tx}, 32'hA0);
    chk("midrst_outs", {10'd0, wr, wr_addr, wr_data, osd_enable, cfg_stb},
        32'd0);
    chk("midrst_hl_cfg", {12'd0, hl_line, cfg}, {12'd0, 4'hF, 16'h0000});
    @(negedge clk); rst_n = 1'b1;
    w0 = n_wr;
    send(0, 8'h02); idle_en();
    chk("midrst_no_wr", n_wr - w0, 0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 9))
        0: send(1, 8'(8'h20 + $urandom_range(0, 15)));
        1: send(1, 8'(8'h40 + $urandom_range(0, 15)));
        2: send(1, 8'(8'h50 + $urandom_range(0, 15)));
        3: send(1, 8'h80);
        4: begin op = 8'($urandom); send(1, op); end
        5: begin drop_cs(); if ($urandom_range(0, 1) == 1) cyc(1'b1, 1'b1, 1'($urandom), 8'($urandom), 1'b0); end
        6: idle_en();
        default: send(0, 8'($urandom));
      endcase
    end
    repeat (3) idle_en();
    chk("wq_drained", wq.size(), 0);
    chk("cq_drained", cq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
